// File: rtl/mem_req_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_buffer
//  Description : Request FIFO between a memory client and the DDR2 controller
//                user interface. Issues requests with a val/rdy handshake,
//                limits reads in flight with a credit counter, registers
//                controller responses back to the client and flags responses
//                that arrive with no read outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_buffer #(
  parameter int DEPTH  = 4,
  parameter int MAX_RD = 4,
  parameter int ADDR_W = 26,
  parameter int DATA_W = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cl_req_val,
  output logic                    cl_req_rdy,
  input  logic                    cl_req_rw,
  input  logic [ADDR_W-1:0]       cl_req_addr,
  input  logic [DATA_W-1:0]       cl_req_data,
  output logic                    cl_resp_val,
  output logic [DATA_W-1:0]       cl_resp_data,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic                    mem_req_rw,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [DATA_W-1:0]       mem_req_data,
  input  logic                    mem_resp_val,
  input  logic [DATA_W-1:0]       mem_resp_data,
  output logic [3:0]              rd_outstanding,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    err_spurious
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [3:0]       RD_LIMIT   = 4'(MAX_RD);

  // FIFO storage, one entry per request
  logic              rw_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       rd_cnt;

  logic push;
  logic pop;
  logic rd_issue;
  logic credit_avail;

  // Client readiness is derived from the registered count only, so there is
  // no combinational path from the controller's rdy back to the client.
  assign cl_req_rdy   = (count != FULL_COUNT);
  assign push         = cl_req_val && cl_req_rdy;

  assign mem_req_rw   = rw_mem[rd_ptr];
  assign mem_req_addr = addr_mem[rd_ptr];
  assign mem_req_data = data_mem[rd_ptr];

  // Writes are never credit-blocked; a read at the head stalls the whole queue.
  assign credit_avail = (rd_cnt != RD_LIMIT);
  assign mem_req_val  = (count != '0) && (mem_req_rw || credit_avail);
  assign pop          = mem_req_val && mem_req_rdy;
  assign rd_issue     = pop && !mem_req_rw;

  assign fifo_count     = count;
  assign rd_outstanding = rd_cnt;

  // Entry storage; cleared on reset so the controller-side outputs read zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rw_mem[i]   <= 1'b0;
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      rw_mem[wr_ptr]   <= cl_req_rw;
      addr_mem[wr_ptr] <= cl_req_addr;
      data_mem[wr_ptr] <= cl_req_data;
    end
  end

  // Pointers wrap modulo DEPTH; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Read credit tracking; a response with nothing outstanding is flagged
  // sticky and the count stays at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt       <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (rd_issue && !mem_resp_val) begin
        rd_cnt <= rd_cnt + 4'd1;
      end else if (!rd_issue && mem_resp_val && (rd_cnt != 4'd0)) begin
        rd_cnt <= rd_cnt - 4'd1;
      end
      if (mem_resp_val && (rd_cnt == 4'd0)) err_spurious <= 1'b1;
    end
  end

  // Registered response path; data holds its last value between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cl_resp_val  <= 1'b0;
      cl_resp_data <= '0;
    end else begin
      cl_resp_val <= mem_resp_val;
      if (mem_resp_val) cl_resp_data <= mem_resp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_buffer
//  Description : Directed self-checking bench for mem_req_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_buffer;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              cl_req_val;
  logic              cl_req_rdy;
  logic              cl_req_rw;
  logic [ADDR_W-1:0] cl_req_addr;
  logic [DATA_W-1:0] cl_req_data;
  logic              cl_resp_val;
  logic [DATA_W-1:0] cl_resp_data;
  logic              mem_req_val;
  logic              mem_req_rdy;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_resp_val;
  logic [DATA_W-1:0] mem_resp_data;
  logic [3:0]        rd_outstanding;
  logic [2:0]        fifo_count;
  logic              err_spurious;

  int tests = 0;
  int fails = 0;

  mem_req_buffer #(.DEPTH(4), .MAX_RD(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cl_req_val(cl_req_val), .cl_req_rdy(cl_req_rdy), .cl_req_rw(cl_req_rw),
    .cl_req_addr(cl_req_addr), .cl_req_data(cl_req_data),
    .cl_resp_val(cl_resp_val), .cl_resp_data(cl_resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
    .rd_outstanding(rd_outstanding), .fifo_count(fifo_count),
    .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests++; if (cl_req_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b want 1", cl_req_rdy); end
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    tests++; if (rd_outstanding !== 4'd0) begin fails++; $display("FAIL reset_rd: got %0d want 0", rd_outstanding); end
    tests++; if (err_spurious !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_spurious); end
    tests++; if (mem_req_val !== 1'b0 || mem_req_addr !== '0 || mem_req_rw !== 1'b0)
      begin fails++; $display("FAIL reset_memreq: val %b addr %0h rw %b want 0", mem_req_val, mem_req_addr, mem_req_rw); end
    tests++; if (cl_resp_val !== 1'b0 || cl_resp_data !== '0)
      begin fails++; $display("FAIL reset_resp: val %b data %0h want 0", cl_resp_val, cl_resp_data); end
  endtask

  task automatic test_write_read();
    mem_req_rdy = 1'b1;
    cl_req_val = 1'b1; cl_req_rw = 1'b1; cl_req_addr = 26'd1; cl_req_data = 256'd5;
    step();
    tests++; if (mem_req_val !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== 26'd1 || mem_req_data !== 256'd5)
      begin fails++; $display("FAIL wr_issue: val %b rw %b addr %0h data %0h want 1 1 1 5", mem_req_val, mem_req_rw, mem_req_addr, mem_req_data); end
    cl_req_rw = 1'b0; cl_req_data = '0;
    step();
    cl_req_val = 1'b0;
    tests++; if (mem_req_val !== 1'b1 || mem_req_rw !== 1'b0 || mem_req_addr !== 26'd1)
      begin fails++; $display("FAIL rd_issue: val %b rw %b addr %0h want 1 0 1", mem_req_val, mem_req_rw, mem_req_addr); end
    tests++; if (rd_outstanding !== 4'd0) begin fails++; $display("FAIL rd_before: got %0d want 0", rd_outstanding); end
    step();  // read accepted on this edge
    tests++; if (rd_outstanding !== 4'd1 || fifo_count !== 3'd0 || mem_req_val !== 1'b0)
      begin fails++; $display("FAIL rd_inflight: rd %0d cnt %0d val %b want 1 0 0", rd_outstanding, fifo_count, mem_req_val); end
    step();
    step();
    mem_resp_val = 1'b1; mem_resp_data = 256'd5;
    step();  // third edge after acceptance
    mem_resp_val = 1'b0; mem_resp_data = 256'd99;
    tests++; if (cl_resp_val !== 1'b1 || cl_resp_data[7:0] !== 8'd5 || rd_outstanding !== 4'd0)
      begin fails++; $display("FAIL rd_resp: val %b data %0h rd %0d want 1 5 0", cl_resp_val, cl_resp_data[7:0], rd_outstanding); end
    step();
    tests++; if (cl_resp_val !== 1'b0 || cl_resp_data[7:0] !== 8'd5)
      begin fails++; $display("FAIL resp_hold: val %b data %0h want 0 5", cl_resp_val, cl_resp_data[7:0]); end
  endtask

  task automatic test_fill();
    int accepted = 0;
    mem_req_rdy = 1'b0;
    cl_req_val = 1'b1; cl_req_rw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cl_req_addr = 26'(i); cl_req_data = 256'(i + 16);
      if (cl_req_rdy) accepted++;
      step();
    end
    cl_req_val = 1'b0;
    tests++; if (accepted != 4) begin fails++; $display("FAIL fill_accepted: got %0d want 4", accepted); end
    tests++; if (cl_req_rdy !== 1'b0 || fifo_count !== 3'd4)
      begin fails++; $display("FAIL fill_full: rdy %b cnt %0d want 0 4", cl_req_rdy, fifo_count); end
    tests++; if (mem_req_val !== 1'b1 || mem_req_addr !== 26'd0)
      begin fails++; $display("FAIL fill_hold: val %b addr %0h want 1 0", mem_req_val, mem_req_addr); end
    mem_req_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem_req_val !== 1'b1 || mem_req_addr !== 26'(i))
        begin fails++; $display("FAIL drain_order: val %b addr %0h want 1 %0h", mem_req_val, mem_req_addr, i); end
      step();
    end
    tests++; if (fifo_count !== 3'd0 || mem_req_val !== 1'b0)
      begin fails++; $display("FAIL drain_empty: cnt %0d val %b want 0 0", fifo_count, mem_req_val); end
  endtask

  task automatic test_credit();
    int pushed = 0;
    int issued = 0;
    mem_req_rdy = 1'b1; cl_req_rw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cl_req_val = (pushed < 6);
      cl_req_addr = 26'(32 + pushed);
      if (cl_req_val && cl_req_rdy) pushed++;
      if (mem_req_val && mem_req_rdy && !mem_req_rw) issued++;
      step();
    end
    cl_req_val = 1'b0;
    tests++; if (pushed != 6 || issued != 4)
      begin fails++; $display("FAIL credit_issued: pushed %0d issued %0d want 6 4", pushed, issued); end
    tests++; if (mem_req_val !== 1'b0 || fifo_count !== 3'd2 || rd_outstanding !== 4'd4)
      begin fails++; $display("FAIL credit_stall: val %b cnt %0d rd %0d want 0 2 4", mem_req_val, fifo_count, rd_outstanding); end
    mem_resp_val = 1'b1;
    step();
    mem_resp_val = 1'b0;
    issued = 0;
    for (int c = 0; c < 5; c++) begin
      if (mem_req_val && mem_req_rdy) issued++;
      step();
    end
    tests++; if (issued != 1 || rd_outstanding !== 4'd4 || fifo_count !== 3'd1 || mem_req_val !== 1'b0)
      begin fails++; $display("FAIL credit_release: issued %0d rd %0d cnt %0d val %b want 1 4 1 0", issued, rd_outstanding, fifo_count, mem_req_val); end
  endtask

  task automatic test_write_bypass();
    cl_req_val = 1'b1; cl_req_rw = 1'b1; cl_req_addr = 26'h20;
    step();
    cl_req_rw = 1'b0; cl_req_addr = 26'h21;
    step();
    cl_req_val = 1'b0;
    tests++; if (mem_req_val !== 1'b0 || fifo_count !== 3'd3)
      begin fails++; $display("FAIL read_blocks_write: val %b cnt %0d want 0 3", mem_req_val, fifo_count); end
    mem_resp_val = 1'b1;
    step();
    mem_resp_val = 1'b0;
    step();  // blocked read issues, credits exhausted again
    tests++; if (mem_req_val !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== 26'h20 || rd_outstanding !== 4'd4)
      begin fails++; $display("FAIL write_bypass: val %b rw %b addr %0h rd %0d want 1 1 20 4", mem_req_val, mem_req_rw, mem_req_addr, rd_outstanding); end
    step();
    tests++; if (mem_req_val !== 1'b0 || fifo_count !== 3'd1 || mem_req_addr !== 26'h21)
      begin fails++; $display("FAIL read_waits: val %b cnt %0d addr %0h want 0 1 21", mem_req_val, fifo_count, mem_req_addr); end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    mem_resp_val = 1'b1;
    step();  // 4 -> 3, read becomes issuable
    step();  // read issue and response on the same edge
    mem_resp_val = 1'b0;
    tests++; if (rd_outstanding !== 4'd3 || fifo_count !== 3'd0)
      begin fails++; $display("FAIL simul_credit: rd %0d cnt %0d want 3 0", rd_outstanding, fifo_count); end
    mem_req_rdy = 1'b0;
    cl_req_val = 1'b1; cl_req_rw = 1'b1; cl_req_addr = 26'h30;
    step();
    cl_req_addr = 26'h31; mem_req_rdy = 1'b1;
    step();  // push and pop together
    cl_req_val = 1'b0;
    tests++; if (fifo_count !== 3'd1 || mem_req_addr !== 26'h31)
      begin fails++; $display("FAIL simul_pushpop: cnt %0d addr %0h want 1 31", fifo_count, mem_req_addr); end
    while (fifo_count != 3'd0 && guard < 10) begin guard++; step(); end
    for (int i = 0; i < 3; i++) begin mem_resp_val = 1'b1; step(); end
    mem_resp_val = 1'b0;
    tests++; if (rd_outstanding !== 4'd0 || err_spurious !== 1'b0 || fifo_count !== 3'd0)
      begin fails++; $display("FAIL settle: rd %0d err %b cnt %0d want 0 0 0", rd_outstanding, err_spurious, fifo_count); end
  endtask

  task automatic test_spurious_reset();
    mem_resp_val = 1'b1; mem_resp_data = 256'hAB;
    step();
    mem_resp_val = 1'b0;
    tests++; if (err_spurious !== 1'b1 || rd_outstanding !== 4'd0 || cl_resp_val !== 1'b1 || cl_resp_data[7:0] !== 8'hAB)
      begin fails++; $display("FAIL spurious: err %b rd %0d val %b data %0h want 1 0 1 ab", err_spurious, rd_outstanding, cl_resp_val, cl_resp_data[7:0]); end
    step(); step();
    tests++; if (err_spurious !== 1'b1) begin fails++; $display("FAIL spurious_sticky: got %b want 1", err_spurious); end
    mem_req_rdy = 1'b0;
    cl_req_val = 1'b1; cl_req_rw = 1'b1;
    for (int i = 0; i < 3; i++) begin cl_req_addr = 26'(i + 64); step(); end
    cl_req_val = 1'b0;
    tests++; if (fifo_count !== 3'd3) begin fails++; $display("FAIL pre_reset_count: got %0d want 3", fifo_count); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++; if (fifo_count !== 3'd0 || mem_req_val !== 1'b0 || err_spurious !== 1'b0)
      begin fails++; $display("FAIL mid_reset: cnt %0d val %b err %b want 0 0 0", fifo_count, mem_req_val, err_spurious); end
  endtask

  initial begin
    reset = 1'b1;
    cl_req_val = 1'b0; cl_req_rw = 1'b0; cl_req_addr = '0; cl_req_data = '0;
    mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
    step(); step();
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_fill();
    test_credit();
    test_write_bypass();
    test_back_to_back();
    test_spurious_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
